// File: rtl/channel_select_ctrl_pkg.sv
// Shared types and constants for the channel selection controller.
package channel_select_ctrl_pkg;

  // Channel index width and encodings shared with rgb_led_manager.
  localparam int CHANNEL_W            = 3;
  localparam int DEFAULT_NUM_CHANNELS = 3;

  localparam logic [CHANNEL_W-1:0] CH_RED   = 3'd0;
  localparam logic [CHANNEL_W-1:0] CH_GREEN = 3'd1;
  localparam logic [CHANNEL_W-1:0] CH_BLUE  = 3'd2;

  typedef enum logic [1:0] {
    DB_RELEASED,
    DB_PRESS_PENDING,
    DB_PRESSED,
    DB_RELEASE_PENDING
  } db_state_e;

  // Step to the following channel, wrapping after the last legal index.
  function automatic logic [CHANNEL_W-1:0] next_channel(
    input logic [CHANNEL_W-1:0] ch,
    input int                   num_ch
  );
    if (ch == CHANNEL_W'(num_ch - 1)) begin
      return '0;
    end
    return ch + CHANNEL_W'(1);
  endfunction

endpackage

// File: rtl/channel_select_ctrl_button_debouncer.sv
// Button conditioner: 2-flop synchroniser, debounce FSM and sample counter.
// Emits a single-cycle press pulse once a press has been stable long enough.
//
//   state              | meaning
//   -------------------+-----------------------------------------------------
//   DB_RELEASED        | button considered up, waiting for a synced high
//   DB_PRESS_PENDING   | counting consecutive high samples toward a press
//   DB_PRESSED         | button considered down, press already reported
//   DB_RELEASE_PENDING | counting consecutive low samples toward a release
module channel_select_ctrl_button_debouncer
  import channel_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next matching sample completes the debounce window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_sync;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  assign btn_sync = sync_q[1];

  // Two-flop synchroniser; the raw pin is not used anywhere else.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Debounce FSM; cnt holds the number of matching samples already seen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DB_RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      unique case (state)
        DB_RELEASED: begin
          cnt <= '0;
          if (btn_sync) begin
            if (CNT_LAST == '0) begin
              state <= DB_PRESSED;
              press <= 1'b1;
            end else begin
              state <= DB_PRESS_PENDING;
              cnt   <= CNT_W'(1);
            end
          end
        end
        DB_PRESS_PENDING: begin
          if (!btn_sync) begin
            state <= DB_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_PRESSED;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DB_PRESSED: begin
          cnt <= '0;
          if (!btn_sync) begin
            if (CNT_LAST == '0) begin
              state <= DB_RELEASED;
            end else begin
              state <= DB_RELEASE_PENDING;
              cnt   <= CNT_W'(1);
            end
          end
        end
        DB_RELEASE_PENDING: begin
          if (btn_sync) begin
            state <= DB_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_RELEASED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= DB_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/channel_select_ctrl.sv
// Channel selection controller: NEXT steps the channel, MODE toggles
// auto-cycling, and in auto mode a fixed timer also steps the channel.
module channel_select_ctrl
  import channel_select_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS    = DEFAULT_NUM_CHANNELS,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_CYCLES     = 100_000_000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 btn_next,
  input  logic                 btn_mode,
  output logic [CHANNEL_W-1:0] curr_channel,
  output logic                 auto_mode,
  output logic                 channel_changed
);

  localparam int TMR_W = $clog2(AUTO_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_CYCLES - 1);

  logic             next_press;
  logic             mode_press;
  logic             timer_expired;
  logic             advance;
  logic [TMR_W-1:0] auto_timer;

  channel_select_ctrl_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clk    (clk),
    .resetn (resetn),
    .btn_raw(btn_next),
    .press  (next_press)
  );

  channel_select_ctrl_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_db (
    .clk    (clk),
    .resetn (resetn),
    .btn_raw(btn_mode),
    .press  (mode_press)
  );

  // A NEXT press and a timer expiry in the same cycle merge into one advance.
  assign timer_expired = auto_mode && (auto_timer == TMR_LAST);
  assign advance       = next_press || timer_expired;

  // Channel, mode and auto timer; any press restarts the full auto period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      curr_channel    <= CH_RED;
      auto_mode       <= 1'b0;
      channel_changed <= 1'b0;
      auto_timer      <= '0;
    end else begin
      channel_changed <= advance;
      if (advance) begin
        curr_channel <= next_channel(curr_channel, NUM_CHANNELS);
      end
      if (mode_press) begin
        auto_mode <= !auto_mode;
      end
      if (!auto_mode || next_press || mode_press || timer_expired) begin
        auto_timer <= '0;
      end else begin
        auto_timer <= auto_timer + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_channel_select_ctrl.sv
// Directed bench for channel_select_ctrl with short debounce/auto periods.
module tb_channel_select_ctrl;

  localparam int NUM_CH = 3;
  localparam int DB_CYC = 4;
  localparam int AUTO_CYC = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic [2:0] curr_channel;
  logic       auto_mode;
  logic       channel_changed;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       nxt;
    logic       mode;
    int         cycles;
    logic [2:0] exp_ch;
    logic       exp_auto;
    int         exp_pulses;
  } seg_t;

  seg_t segs[12];

  channel_select_ctrl #(
    .NUM_CHANNELS   (NUM_CH),
    .DEBOUNCE_CYCLES(DB_CYC),
    .AUTO_CYCLES    (AUTO_CYC)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .btn_next       (btn_next),
    .btn_mode       (btn_mode),
    .curr_channel   (curr_channel),
    .auto_mode      (auto_mode),
    .channel_changed(channel_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      pulses += int'(channel_changed);
    end
  endtask

  function automatic int model_next(input int ch);
    return (ch == NUM_CH - 1) ? 0 : ch + 1;
  endfunction

  initial begin
    int p;
    int exp_ch;

    // test 1: reset values, then a long NEXT hold gives exactly one advance
    resetn = 1'b0;
    repeat (3) tick();
    check("reset_ch", int'(curr_channel), 0);
    check("reset_auto", int'(auto_mode), 0);
    check("reset_changed", int'(channel_changed), 0);
    resetn = 1'b1;
    repeat (2) tick();

    btn_next = 1'b1;
    run(6, p);
    check("t1_no_early_pulse", p, 0);
    check("t1_no_early_ch", int'(curr_channel), 0);
    tick();
    check("t1_ch_at_edge7", int'(curr_channel), 1);
    check("t1_changed_at_edge7", int'(channel_changed), 1);
    run(13, p);
    check("t1_no_repeat", p, 0);
    check("t1_ch_hold", int'(curr_channel), 1);
    btn_next = 1'b0;
    run(8, p);
    check("t1_release_no_pulse", p, 0);

    // tests 2 and 3: clean presses with wrap, a short glitch, a release bounce
    segs[0]  = '{1'b1, 1'b0, 8, 3'd2, 1'b0, 1};
    segs[1]  = '{1'b0, 1'b0, 8, 3'd2, 1'b0, 0};
    segs[2]  = '{1'b1, 1'b0, 8, 3'd0, 1'b0, 1};
    segs[3]  = '{1'b0, 1'b0, 8, 3'd0, 1'b0, 0};
    segs[4]  = '{1'b1, 1'b0, 8, 3'd1, 1'b0, 1};
    segs[5]  = '{1'b0, 1'b0, 8, 3'd1, 1'b0, 0};
    segs[6]  = '{1'b1, 1'b0, 3, 3'd1, 1'b0, 0};
    segs[7]  = '{1'b0, 1'b0, 8, 3'd1, 1'b0, 0};
    segs[8]  = '{1'b1, 1'b0, 8, 3'd2, 1'b0, 1};
    segs[9]  = '{1'b0, 1'b0, 2, 3'd2, 1'b0, 0};
    segs[10] = '{1'b1, 1'b0, 1, 3'd2, 1'b0, 0};
    segs[11] = '{1'b0, 1'b0, 8, 3'd2, 1'b0, 0};
    for (int i = 0; i < 12; i++) begin
      btn_next = segs[i].nxt;
      btn_mode = segs[i].mode;
      run(segs[i].cycles, p);
      check($sformatf("seg%0d_ch", i), int'(curr_channel), int'(segs[i].exp_ch));
      check($sformatf("seg%0d_auto", i), int'(auto_mode), int'(segs[i].exp_auto));
      check($sformatf("seg%0d_pulses", i), p, segs[i].exp_pulses);
    end

    // test 4: MODE press enables auto mode; advances every AUTO_CYC cycles
    btn_mode = 1'b1;
    run(6, p);
    check("t4_auto_early", int'(auto_mode), 0);
    tick();
    check("t4_auto_on", int'(auto_mode), 1);
    check("t4_no_pulse_on_toggle", int'(channel_changed), 0);
    check("t4_ch_kept", int'(curr_channel), 2);
    btn_mode = 1'b0;
    exp_ch = 2;
    for (int k = 0; k < 3; k++) begin
      run(9, p);
      check($sformatf("t4_quiet%0d", k), p, 0);
      check($sformatf("t4_hold%0d", k), int'(curr_channel), exp_ch);
      tick();
      exp_ch = model_next(exp_ch);
      check($sformatf("t4_adv%0d_ch", k), int'(curr_channel), exp_ch);
      check($sformatf("t4_adv%0d_changed", k), int'(channel_changed), 1);
    end

    // test 5: NEXT pulse coincides with timer expiry -> single advance
    run(3, p);
    btn_next = 1'b1;
    run(6, p);
    check("t5_pre_pulses", p, 0);
    tick();
    check("t5_single_adv_ch", int'(curr_channel), model_next(exp_ch));
    check("t5_single_adv_changed", int'(channel_changed), 1);
    exp_ch = model_next(exp_ch);
    tick();
    check("t5_no_double_changed", int'(channel_changed), 0);
    check("t5_no_double_ch", int'(curr_channel), exp_ch);
    btn_next = 1'b0;
    run(8, p);
    check("t5_gap_pulses", p, 0);
    tick();
    exp_ch = model_next(exp_ch);
    check("t5_next_auto_ch", int'(curr_channel), exp_ch);
    check("t5_next_auto_changed", int'(channel_changed), 1);

    // test 5b: NEXT mid-period restarts the full auto period
    tick();
    btn_next = 1'b1;
    run(6, p);
    check("t5b_pre_pulses", p, 0);
    tick();
    exp_ch = model_next(exp_ch);
    check("t5b_next_ch", int'(curr_channel), exp_ch);
    btn_next = 1'b0;
    run(2, p);
    check("t5b_old_expiry_suppressed", p, 0);
    run(7, p);
    check("t5b_gap_pulses", p, 0);
    tick();
    exp_ch = model_next(exp_ch);
    check("t5b_auto_ch", int'(curr_channel), exp_ch);
    check("t5b_auto_changed", int'(channel_changed), 1);

    // test 6: async reset mid-timer and mid-debounce, button held through it
    run(9, p);
    tick();
    exp_ch = model_next(exp_ch);
    check("t6_pre_ch", int'(curr_channel), exp_ch);
    btn_next = 1'b1;
    run(4, p);
    check("t6_pending_no_pulse", p, 0);
    resetn = 1'b0;
    #2;
    check("t6_async_ch", int'(curr_channel), 0);
    check("t6_async_auto", int'(auto_mode), 0);
    check("t6_async_changed", int'(channel_changed), 0);
    repeat (3) tick();
    resetn = 1'b1;
    run(6, p);
    check("t6_post_no_early", p, 0);
    check("t6_post_ch0", int'(curr_channel), 0);
    tick();
    check("t6_held_press_ch", int'(curr_channel), 1);
    check("t6_held_press_changed", int'(channel_changed), 1);
    run(20, p);
    check("t6_no_repeat", p, 0);
    check("t6_auto_off", int'(auto_mode), 0);
    btn_next = 1'b0;
    run(8, p);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
